// File: rtl/pipe_rr_arb_pkg.sv
// Shared helpers for the round-robin pipelined arbiter: width derivations
// and the modular index arithmetic used by the round-robin search.
package pipe_arb_pkg;

  localparam int DEFAULT_DEPTH = 2;

  // ceil(log2(n)), never less than 1, so a 1-entry range still gets a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  // Width of a requester index.
  function automatic int id_width(input int nreq);
    return clog2_min1(nreq);
  endfunction

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return clog2_min1(depth + 1);
  endfunction

  // (a + b) mod n for 0 <= a < n and 0 <= b < n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/pipe_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i at or above
// ptr_i, wrapping modulo NREQ.
module rr_pick
  import pipe_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  grant_o,
  output logic            any_o
);

  // Doubled vector shifted by ptr: bit k is requester (ptr + k) mod NREQ.
  logic [2*NREQ-1:0] rot;

  // Rotate so the search always starts at bit 0, then take the first hit.
  always_comb begin
    rot     = {valid_i, valid_i} >> ptr_i;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_o && rot[k]) begin
        any_o   = 1'b1;
        grant_o = IDW'(wrap_add(int'(ptr_i), k, NREQ));
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arb.sv
// Round-robin arbiter feeding a rigid DEPTH-stage shift pipeline. Each word
// carries its requester id to the last stage, which is the output register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is one-hot-or-zero and depends combinationally on
// req_valid and out_ready; out_valid/out_data/out_id come straight from the
// last pipeline stage and never from req_*.
module pipe_rr_arb
  import pipe_arb_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int DW    = 1,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int IDW   = id_width(NREQ),
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [IDW-1:0]       out_id,
  input  logic                 out_ready,
  output logic [CW-1:0]        inflight
);

  logic           valid_q [DEPTH];
  logic [DW-1:0]  data_q  [DEPTH];
  logic [IDW-1:0] id_q    [DEPTH];
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IDW-1:0] grant;
  logic           any_req;
  logic           advance;
  logic           accept;
  logic           pop;
  logic [DW-1:0]  in_word;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .any_o   (any_req)
  );

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];
  assign inflight  = cnt_q;

  // The whole chain moves only when the output slot is empty or draining.
  always_comb begin
    advance = !valid_q[DEPTH-1] || out_ready;
    accept  = advance && any_req;
    pop     = valid_q[DEPTH-1] && out_ready;
  end

  // Select the granted requester's word.
  always_comb begin
    in_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) in_word = req_data[i*DW +: DW];
    end
  end

  // One-hot ready for the winner; held low while reset is asserted because
  // the empty pipeline would otherwise advertise acceptance.
  always_comb begin
    req_ready = '0;
    if (accept && rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant == IDW'(i)) req_ready[i] = 1'b1;
      end
    end
  end

  // Next pointer and occupancy: pointer moves past the winner, count tracks
  // one word in and one word out per edge.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    cnt_d = cnt_q + CW'(accept) - CW'(pop);
  end

  // Pipeline stages, round-robin pointer and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        id_q[i]    <= '0;
      end
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (advance) begin
        valid_q[0] <= accept;
        data_q[0]  <= accept ? in_word : '0;
        id_q[0]    <= accept ? grant : '0;
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
          id_q[i]    <= id_q[i-1];
        end
      end
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_rr_arb.sv
// Bench for pipe_rr_arb: directed scenarios on a 2-requester, 2-stage,
// 1-bit instance and a random run on a 3-requester, 4-stage, 8-bit instance.
module tb_pipe_rr_arb;

  localparam int A_NREQ = 2, A_DW = 1, A_DEPTH = 2, A_IDW = 1, A_CW = 2;
  localparam int B_NREQ = 3, B_DW = 8, B_DEPTH = 4, B_IDW = 2, B_CW = 3;
  localparam int AW = A_IDW + A_DW;
  localparam int BW = B_IDW + B_DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic [A_NREQ-1:0]      a_req_valid, a_req_ready;
  logic [A_NREQ*A_DW-1:0] a_req_data;
  logic                   a_out_valid, a_out_ready;
  logic [A_DW-1:0]        a_out_data;
  logic [A_IDW-1:0]       a_out_id;
  logic [A_CW-1:0]        a_inflight;

  pipe_rr_arb #(.NREQ(A_NREQ), .DW(A_DW), .DEPTH(A_DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_data(a_req_data), .req_ready(a_req_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_id(a_out_id),
    .out_ready(a_out_ready), .inflight(a_inflight)
  );

  // ---------------- DUT B ----------------
  logic [B_NREQ-1:0]      b_req_valid, b_req_ready;
  logic [B_NREQ*B_DW-1:0] b_req_data;
  logic                   b_out_valid, b_out_ready;
  logic [B_DW-1:0]        b_out_data;
  logic [B_IDW-1:0]       b_out_id;
  logic [B_CW-1:0]        b_inflight;

  pipe_rr_arb #(.NREQ(B_NREQ), .DW(B_DW), .DEPTH(B_DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_data(b_req_data), .req_ready(b_req_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_id(b_out_id),
    .out_ready(b_out_ready), .inflight(b_inflight)
  );

  // ---------------- scoreboard / model state ----------------
  int n_pass = 0;
  int n_total = 0;

  logic [AW-1:0] exp_q[$];
  int            lat_q[$];
  logic [BW-1:0] exp_b_q[$];

  logic m_vld [A_DEPTH];
  int   m_ptr;
  int   m_cnt;
  int   cyc;
  logic chk_lat;

  task automatic model_clear_a();
    for (int i = 0; i < A_DEPTH; i++) m_vld[i] = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    exp_q.delete();
    lat_q.delete();
  endtask

  // One clock of DUT A: called just after a negedge with inputs driven.
  // Checks arbitration against the reference model, scores output words,
  // then advances the model across the rising edge.
  task automatic step_a(input string tag);
    int g;
    int idx;
    int t;
    logic adv;
    logic pop;
    logic [A_NREQ-1:0] exp_rr;
    logic [AW-1:0] e;
    #1;
    adv = !m_vld[A_DEPTH-1] || a_out_ready;
    g = -1;
    if (adv) begin
      for (int k = 0; k < A_NREQ; k++) begin
        idx = (m_ptr + k) % A_NREQ;
        if (g < 0 && a_req_valid[idx]) g = idx;
      end
    end
    exp_rr = '0;
    if (g >= 0) exp_rr[g] = 1'b1;

    n_total++;
    if (a_req_ready !== exp_rr)
      $display("FAIL %s req_ready: got %b want %b", tag, a_req_ready, exp_rr);
    else n_pass++;
    n_total++;
    if (a_out_valid !== m_vld[A_DEPTH-1])
      $display("FAIL %s out_valid: got %b want %b", tag, a_out_valid, m_vld[A_DEPTH-1]);
    else n_pass++;
    n_total++;
    if (a_inflight !== A_CW'(m_cnt))
      $display("FAIL %s inflight: got %0d want %0d", tag, a_inflight, m_cnt);
    else n_pass++;

    if (g >= 0) begin
      exp_q.push_back({A_IDW'(g), a_req_data[g*A_DW +: A_DW]});
      lat_q.push_back(cyc);
    end

    if (a_out_valid && a_out_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s unexpected_word: got id=%0d data=%0h want none", tag, a_out_id, a_out_data);
      end else begin
        e = exp_q.pop_front();
        t = lat_q.pop_front();
        if ({a_out_id, a_out_data} !== e)
          $display("FAIL %s out_word: got id=%0d data=%0h want id=%0d data=%0h",
                   tag, a_out_id, a_out_data, e[AW-1 -: A_IDW], e[A_DW-1:0]);
        else n_pass++;
        if (chk_lat) begin
          n_total++;
          if (cyc - t != A_DEPTH)
            $display("FAIL %s latency: got %0d want %0d", tag, cyc - t, A_DEPTH);
          else n_pass++;
        end
      end
    end

    pop = m_vld[A_DEPTH-1] && a_out_ready;
    if (adv) begin
      for (int i = A_DEPTH - 1; i > 0; i--) m_vld[i] = m_vld[i-1];
      m_vld[0] = (g >= 0);
    end
    if (g >= 0) m_ptr = (g + 1) % A_NREQ;
    m_cnt = m_cnt + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain_a(input string tag);
    a_req_valid = '0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() > 0 || m_cnt > 0); i++) step_a(tag);
    n_total++;
    if (exp_q.size() != 0 || a_inflight !== '0)
      $display("FAIL %s drain: got pending=%0d inflight=%0d want 0/0", tag, exp_q.size(), a_inflight);
    else n_pass++;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    a_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear_a();
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    a_req_valid = 2'b11;
    a_req_data = 2'b11;
    a_out_ready = 1'b0;
    #3;
    n_total++;
    if (a_req_ready !== '0) $display("FAIL reset req_ready: got %b want 00", a_req_ready);
    else n_pass++;
    n_total++;
    if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_id !== '0)
      $display("FAIL reset out: got v=%b d=%0h id=%0d want 0/0/0", a_out_valid, a_out_data, a_out_id);
    else n_pass++;
    n_total++;
    if (a_inflight !== '0) $display("FAIL reset inflight: got %0d want 0", a_inflight);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_req_valid = '0;
    model_clear_a();
  endtask

  task automatic test_single();
    logic [3:0] pat;
    pat = 4'b1101;
    chk_lat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_req_valid = 2'b01;
      a_req_data = {1'b0, pat[i]};
      a_out_ready = 1'b1;
      step_a("single");
    end
    #1;
    n_total++;
    if (a_inflight !== A_CW'(2)) $display("FAIL single inflight_settle: got %0d want 2", a_inflight);
    else n_pass++;
    drain_a("single_drain");
  endtask

  task automatic test_round_robin();
    pulse_reset();
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_req_valid = 2'b11;
      a_req_data = 2'($urandom_range(0, 3));
      a_out_ready = 1'b1;
      #1;
      n_total++;
      if (a_req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL rr grant%0d: got %b want %b", i, a_req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
      if (i >= 2) begin
        n_total++;
        if (a_out_valid !== 1'b1 || a_out_id !== A_IDW'(i % 2))
          $display("FAIL rr out_id%0d: got v=%b id=%0d want v=1 id=%0d", i, a_out_valid, a_out_id, i % 2);
        else n_pass++;
      end
      step_a("rr");
    end
    drain_a("rr_drain");
  endtask

  task automatic test_backpressure();
    logic [A_DW-1:0] w0;
    chk_lat = 1'b0;
    w0 = A_DW'($urandom_range(0, 1));
    a_out_ready = 1'b0;
    a_req_valid = 2'b01;
    a_req_data = {1'b0, w0};
    step_a("bp_fill");
    a_req_data = {1'b0, ~w0};
    step_a("bp_fill");
    for (int i = 0; i < 3; i++) begin
      a_req_valid = 2'b01;
      a_out_ready = 1'b0;
      #1;
      n_total++;
      if (a_req_ready !== '0 || a_inflight !== A_CW'(2))
        $display("FAIL bp_hold%0d: got ready=%b inflight=%0d want 00/2", i, a_req_ready, a_inflight);
      else n_pass++;
      n_total++;
      if (a_out_valid !== 1'b1 || a_out_data !== w0 || a_out_id !== '0)
        $display("FAIL bp_stable%0d: got v=%b d=%0h id=%0d want 1/%0h/0", i, a_out_valid, a_out_data, a_out_id, w0);
      else n_pass++;
      step_a("bp_hold");
    end
    for (int i = 0; i < 2; i++) begin
      a_req_valid = '0;
      a_out_ready = 1'b1;
      #1;
      n_total++;
      if (a_out_valid !== 1'b1)
        $display("FAIL bp_release%0d: got out_valid=%b want 1", i, a_out_valid);
      else n_pass++;
      step_a("bp_release");
    end
    drain_a("bp_drain");
  endtask

  task automatic test_bubble();
    chk_lat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_req_valid = (i == 0) ? 2'b01 : 2'b00;
      a_req_data = 2'b01;
      a_out_ready = 1'b1;
      #1;
      n_total++;
      if (a_out_valid !== (i == 2))
        $display("FAIL bubble out_valid%0d: got %b want %b", i, a_out_valid, (i == 2));
      else n_pass++;
      if (i >= 1 && i <= 3) begin
        n_total++;
        if (a_inflight !== ((i == 3) ? A_CW'(0) : A_CW'(1)))
          $display("FAIL bubble inflight%0d: got %0d want %0d", i, a_inflight, (i == 3) ? 0 : 1);
        else n_pass++;
      end
      step_a("bubble");
    end
  endtask

  task automatic test_reset_midstream();
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_req_valid = 2'b11;
      a_req_data = 2'($urandom_range(0, 3));
      a_out_ready = 1'b1;
      step_a("mid_stream");
    end
    a_req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (a_out_valid !== 1'b0 || a_inflight !== '0 || a_req_ready !== '0)
      $display("FAIL mid_reset: got v=%b inflight=%0d ready=%b want 0/0/00", a_out_valid, a_inflight, a_req_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear_a();
    a_req_valid = 2'b11;
    #1;
    n_total++;
    if (a_req_ready !== 2'b01) $display("FAIL mid_first_grant: got %b want 01", a_req_ready);
    else n_pass++;
    step_a("mid_after");
    drain_a("mid_drain");
  endtask

  // ---------------- random test on DUT B ----------------
  task automatic test_random_b();
    logic           pend [B_NREQ];
    logic [B_DW-1:0] dat [B_NREQ];
    int             seq  [B_NREQ];
    int             waitc[B_NREQ];
    int             cnt;
    logic           exp_any;
    logic [BW-1:0]  e;
    int             max_wait;
    int             drained;
    cnt = 0;
    max_wait = 0;
    for (int i = 0; i < B_NREQ; i++) begin
      pend[i] = 1'b0; dat[i] = '0; seq[i] = 0; waitc[i] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < B_NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1'b1;
          dat[i] = B_DW'(seq[i]);
          waitc[i] = 0;
        end
        b_req_valid[i] = pend[i];
        b_req_data[i*B_DW +: B_DW] = dat[i];
      end
      b_out_ready = ($urandom_range(0, 99) < 70);
      #1;
      exp_any = (!b_out_valid || b_out_ready) && (|b_req_valid);
      n_total++;
      if ($countones(b_req_ready) > 1 || (b_req_ready & ~b_req_valid) != '0 || (|b_req_ready) !== exp_any)
        $display("FAIL rnd grant c%0d: got ready=%b valid=%b want any=%b", c, b_req_ready, b_req_valid, exp_any);
      else n_pass++;
      n_total++;
      if (b_inflight !== B_CW'(cnt) || cnt > B_DEPTH)
        $display("FAIL rnd inflight c%0d: got %0d want %0d", c, b_inflight, cnt);
      else n_pass++;
      for (int i = 0; i < B_NREQ; i++) begin
        if (b_req_ready[i]) begin
          exp_b_q.push_back({B_IDW'(i), dat[i]});
          pend[i] = 1'b0;
          seq[i]++;
          cnt++;
          for (int j = 0; j < B_NREQ; j++) begin
            if (j != i && pend[j]) begin
              waitc[j]++;
              if (waitc[j] > max_wait) max_wait = waitc[j];
            end
          end
        end
      end
      if (b_out_valid && b_out_ready) begin
        n_total++;
        if (exp_b_q.size() == 0) begin
          $display("FAIL rnd unexpected_word c%0d: got id=%0d data=%0h", c, b_out_id, b_out_data);
        end else begin
          e = exp_b_q.pop_front();
          if ({b_out_id, b_out_data} !== e)
            $display("FAIL rnd out_word c%0d: got id=%0d data=%0h want id=%0d data=%0h",
                     c, b_out_id, b_out_data, e[BW-1 -: B_IDW], e[B_DW-1:0]);
          else n_pass++;
        end
        cnt--;
      end
      @(negedge clk);
    end
    n_total++;
    if (max_wait > B_NREQ - 1)
      $display("FAIL rnd fairness: got max wait %0d want <= %0d", max_wait, B_NREQ - 1);
    else n_pass++;
    b_req_valid = '0;
    b_out_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 40 && exp_b_q.size() > 0; c++) begin
      #1;
      if (b_out_valid) begin
        e = exp_b_q.pop_front();
        n_total++;
        if ({b_out_id, b_out_data} !== e)
          $display("FAIL rnd drain_word: got id=%0d data=%0h want id=%0d data=%0h",
                   b_out_id, b_out_data, e[BW-1 -: B_IDW], e[B_DW-1:0]);
        else n_pass++;
        drained++;
      end
      @(negedge clk);
    end
    #1;
    n_total++;
    if (exp_b_q.size() != 0 || b_inflight !== '0 || b_out_valid !== 1'b0)
      $display("FAIL rnd final: got pending=%0d inflight=%0d v=%b want 0/0/0",
               exp_b_q.size(), b_inflight, b_out_valid);
    else n_pass++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0;
    a_req_valid = '0; a_req_data = '0; a_out_ready = 1'b0;
    b_req_valid = '0; b_req_data = '0; b_out_ready = 1'b0;
    cyc = 0;
    chk_lat = 1'b0;
    model_clear_a();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_bubble();
    test_reset_midstream();
    @(negedge clk);
    test_random_b();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Time bound for the whole run.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
